hazard_ctrl: RTL and testbench

- Pipeline hazard/stall controller for the five-stage RV32I core; works alongside the EX/MEM/WB operand-forwarding logic.
- Detects hazards that forwarding cannot resolve (load-use, taken branch/jump, data-memory wait states).
- Drives stall/flush/bubble controls into the PC, IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers.
- Tracks data-memory waits with a small FSM and a timeout counter.

---
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use / taken-branch / data-memory-wait hazard control; outputs are combinational (0-cycle),
// a memory wait holds every upstream stage and bubbles MEM/WB. Define HAZARD_PERF_CNT_EN for stall/flush perf counters.
module hazard_ctrl #(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1_addr,
  input  logic [4:0] id_rs2_addr,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic       id_is_store,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd_addr,
  input  logic       ex_branch_taken,
  input  logic       me_mem_req,
  input  logic       me_mem_ready,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       if_id_flush,
  output logic       id_ex_stall,
  output logic       id_ex_flush,
  output logic       ex_me_stall,
  output logic       me_wb_bubble,
  output logic       mem_timeout,
  output logic       mem_wait
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cnt,
  output logic [31:0] perf_flush_cnt
`endif
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  localparam logic [CNT_W-1:0] TO_VAL  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             timeout_nxt;
  logic             memstall;
  logic             lu;

  assign memstall = me_mem_req & ~me_mem_ready;

  // Stores get rs2 (data) from MEM-stage forwarding, so only their rs1 can cause a load-use stall.
  assign lu = ex_mem_read & (ex_rd_addr != 5'd0) &
              ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
               (id_rs2_used & ~id_is_store & (id_rs2_addr == ex_rd_addr)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      cnt         <= '0;
      mem_timeout <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mem_timeout <= timeout_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    timeout_nxt = mem_timeout;
    case (state)
      RUN: begin
        cnt_nxt = '0;
        if (memstall) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
        if (me_mem_ready) begin
          state_nxt = RUN;
        end else if ((TIMEOUT_CYCLES != 0) && (cnt_nxt == TO_VAL)) begin
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  assign mem_wait = (state == MEM_WAIT);

  // Priority: memory wait freezes everything (a frozen taken branch re-resolves later), then branch, then load-use.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_me_stall  = 1'b0;
    me_wb_bubble = 1'b0;
    if (!rst) begin
      if (memstall) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_me_stall  = 1'b1;
        me_wb_bubble = 1'b1;
      end else if (ex_branch_taken) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (lu) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      perf_stall_cnt <= perf_stall_cnt + 32'(pc_stall);
      perf_flush_cnt <= perf_flush_cnt + 32'(if_id_flush | id_ex_flush);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a behavioural model (TIMEOUT_CYCLES = 4).
module tb_hazard_ctrl;

  localparam int TO = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs1_addr, id_rs2_addr, ex_rd_addr;
  logic       id_rs1_used, id_rs2_used, id_is_store;
  logic       ex_mem_read, ex_branch_taken, me_mem_req, me_mem_ready;
  logic       pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic       ex_me_stall, me_wb_bubble, mem_timeout, mem_wait;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  // model state: waiting on memory, wait cycles seen, sticky timeout, perf totals
  bit          m_wait;
  int          m_k;
  bit          m_to;
  logic [31:0] m_stalls, m_flushes;

  always #5 clk = ~clk;

  hazard_ctrl #(.TIMEOUT_CYCLES(TO), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .id_rs1_addr(id_rs1_addr), .id_rs2_addr(id_rs2_addr),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_is_store(id_is_store),
    .ex_mem_read(ex_mem_read), .ex_rd_addr(ex_rd_addr), .ex_branch_taken(ex_branch_taken),
    .me_mem_req(me_mem_req), .me_mem_ready(me_mem_ready),
    .pc_stall(pc_stall), .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush), .ex_me_stall(ex_me_stall),
    .me_wb_bubble(me_wb_bubble), .mem_timeout(mem_timeout), .mem_wait(mem_wait)
`ifdef HAZARD_PERF_CNT_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_in(input bit mr, input int rd, input int r1, input bit u1, input int r2,
                        input bit u2, input bit st, input bit br, input bit rq, input bit rdy);
    ex_mem_read = mr;  ex_rd_addr  = 5'(rd);
    id_rs1_addr = 5'(r1); id_rs1_used = u1;
    id_rs2_addr = 5'(r2); id_rs2_used = u2; id_is_store = st;
    ex_branch_taken = br; me_mem_req = rq; me_mem_ready = rdy;
  endtask

  // One cycle: compare at negedge, then advance the model on the rising edge.
  task automatic step();
    bit ms, hz, e_pc, e_ifs, e_iff, e_ids, e_idf, e_exs, e_bub;
    @(negedge clk);
    ms = me_mem_req && !me_mem_ready;
    hz = ex_mem_read && ex_rd_addr != 0 &&
         ((id_rs1_used && id_rs1_addr == ex_rd_addr) ||
          (id_rs2_used && !id_is_store && id_rs2_addr == ex_rd_addr));
    e_pc = 0; e_ifs = 0; e_iff = 0; e_ids = 0; e_idf = 0; e_exs = 0; e_bub = 0;
    if (rst) begin
    end else if (ms) begin
      e_pc = 1; e_ifs = 1; e_ids = 1; e_exs = 1; e_bub = 1;
    end else if (ex_branch_taken) begin
      e_iff = 1; e_idf = 1;
    end else if (hz) begin
      e_pc = 1; e_ifs = 1; e_idf = 1;
    end
    check_eq("pc_stall", pc_stall, e_pc);
    check_eq("if_id_stall", if_id_stall, e_ifs);
    check_eq("if_id_flush", if_id_flush, e_iff);
    check_eq("id_ex_stall", id_ex_stall, e_ids);
    check_eq("id_ex_flush", id_ex_flush, e_idf);
    check_eq("ex_me_stall", ex_me_stall, e_exs);
    check_eq("me_wb_bubble", me_wb_bubble, e_bub);
    if (!rst) begin
      check_eq("mem_wait", mem_wait, m_wait);
      check_eq("mem_timeout", mem_timeout, m_to);
`ifdef HAZARD_PERF_CNT_EN
      check_eq("perf_stall", perf_stall_cnt, m_stalls);
      check_eq("perf_flush", perf_flush_cnt, m_flushes);
`endif
    end
    @(posedge clk);
    if (rst) begin
      m_wait = 0; m_k = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
    end else begin
      m_stalls  = m_stalls + 32'(e_pc);
      m_flushes = m_flushes + 32'(e_iff | e_idf);
      if (!m_wait) begin
        m_wait = ms;
        m_k = 0;
      end else begin
        m_k++;
        if (me_mem_ready) begin
          m_wait = 0;
          m_k = 0;
        end else if (TO != 0 && m_k >= TO) begin
          m_to = 1;
        end
      end
    end
    #1;
  endtask

  initial begin
    m_wait = 0; m_k = 0; m_to = 0; m_stalls = 0; m_flushes = 0;
    rst = 1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    rst = 0;
    step();
    check_eq("reset_wait", mem_wait, 0);
    check_eq("reset_timeout", mem_timeout, 0);

    // load-use on rs1, then same with rd = x0
    set_in(1, 5, 5, 1, 9, 0, 0, 0, 0, 0); step();
    set_in(1, 0, 0, 1, 0, 1, 0, 0, 0, 0); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    // store data dependency only -> no stall; store base dependency -> stall
    set_in(1, 7, 3, 1, 7, 1, 1, 0, 0, 0); step();
    set_in(1, 7, 7, 1, 3, 1, 1, 0, 0, 0); step();
    // branch wins over load-use
    set_in(1, 5, 5, 1, 5, 1, 0, 1, 0, 0); step();
    // zero-wait access
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    // 3-cycle memory wait with a taken branch frozen in EX
    for (int i = 0; i < 3; i++) begin
      set_in(1, 5, 5, 1, 0, 0, 0, 1, 1, 0); step();
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check_eq("wait_done", mem_wait, 0);

    // timeout: ready held low for 10 cycles
    for (int i = 0; i < 10; i++) begin
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); step();
    end
    check_eq("timeout_set", mem_timeout, 1);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1); step();
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step(); step();
    check_eq("timeout_sticky", mem_timeout, 1);

    // reset in the middle of a wait
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 1, 0); step(); step();
    rst = 1; step();
    rst = 0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); step();
    check_eq("rst_mid_wait", mem_wait, 0);
    check_eq("rst_clr_timeout", mem_timeout, 0);

    // random traffic, alternating fast and slow memory phases
    for (int i = 0; i < 3000; i++) begin
      int rdy_pct;
      rdy_pct = ((i / 100) % 2 == 0) ? 60 : 10;
      rst = ($urandom_range(0, 59) == 0);
      set_in($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 3),
             $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1),
             ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 2) == 0), ($urandom_range(0, 99) < rdy_pct));
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
